// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the register file's single write port between NUM_REQ writeback
// sources. A round-robin arbiter picks one requester per cycle. A single
// registered write stage drives the regfile write port. A pending-write
// (busy) scoreboard lets the issue stage stall on operands that have not
// been written back yet.
//
// Requester order: 0 = ALU, 1 = multdiv, 2 = load.
// Register 0 is hardwired: writes to it are accepted but dropped, and it is
// never marked busy.

module regfile_wb_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                                clock,
    input  logic                                ctrl_reset,

    // writeback requesters
    input  logic [NUM_REQ-1:0]                  wb_req,
    input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]   wb_reg,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]       wb_data,
    output logic [NUM_REQ-1:0]                  wb_grant,

    // scoreboard allocation and lookup
    input  logic                                alloc_valid,
    input  logic [REG_ADDR_WIDTH-1:0]           alloc_reg,
    input  logic [REG_ADDR_WIDTH-1:0]           query_regA,
    input  logic [REG_ADDR_WIDTH-1:0]           query_regB,
    output logic                                busyA,
    output logic                                busyB,
    output logic [(1<<REG_ADDR_WIDTH)-1:0]      busy_vector,

    // regfile write port
    output logic                                ctrl_writeEnable,
    output logic [REG_ADDR_WIDTH-1:0]           ctrl_writeReg,
    output logic [DATA_WIDTH-1:0]               data_writeReg
);

    // ------------------------------------------------------------------
    // Local parameters
    // ------------------------------------------------------------------
    localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Requester index reached by stepping 'step' places from 'base',
    // wrapping modulo NUM_REQ. Both inputs are always below NUM_REQ, so
    // a single conditional subtract is enough.
    function automatic int rr_index(input int base, input int step);
        int sum;
        sum = base + step;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end else begin
            sum = sum;
        end
        return sum;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]          r_rr_ptr;
    logic [NUM_REGS-1:0]       r_busy;
    logic                      r_write_en;
    logic [REG_ADDR_WIDTH-1:0] r_write_reg;
    logic [DATA_WIDTH-1:0]     r_write_data;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic                      w_grant_valid;
    logic [PTR_W-1:0]          w_grant_idx;
    logic [NUM_REQ-1:0]        w_grant;
    logic [PTR_W-1:0]          w_rr_ptr_next;
    logic [REG_ADDR_WIDTH-1:0] w_sel_reg;
    logic [DATA_WIDTH-1:0]     w_sel_data;
    logic                      w_sel_is_r0;
    logic [NUM_REGS-1:0]       w_busy_next;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------

    // Round-robin search starting at r_rr_ptr; the first requester found wins.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = {PTR_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_grant_valid && wb_req[rr_index(int'(r_rr_ptr), k)]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = PTR_W'(rr_index(int'(r_rr_ptr), k));
            end else begin
                w_grant_valid = w_grant_valid;
            end
        end
    end

    // Expand the winning index into a one-hot grant vector.
    always_comb begin
        w_grant = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            w_grant[i] = w_grant_valid && (w_grant_idx == PTR_W'(i));
        end
    end

    // The pointer moves past the winner; with no grant it holds.
    always_comb begin
        w_rr_ptr_next = r_rr_ptr;
        if (w_grant_valid) begin
            w_rr_ptr_next = PTR_W'(rr_index(int'(w_grant_idx), 1));
        end else begin
            w_rr_ptr_next = r_rr_ptr;
        end
    end

    // The grant is combinational but is held low while reset is asserted,
    // so no requester believes its transfer completed during reset.
    assign wb_grant = ctrl_reset ? {NUM_REQ{1'b0}} : w_grant;

    // Round-robin pointer register.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_rr_ptr <= {PTR_W{1'b0}};
        end else begin
            r_rr_ptr <= w_rr_ptr_next;
        end
    end

    // ------------------------------------------------------------------
    // Write-stage data selection
    // ------------------------------------------------------------------

    // AND-OR mux of the granted requester's register and data. The grant is
    // one-hot, so at most one term is non-zero.
    always_comb begin
        w_sel_reg  = {REG_ADDR_WIDTH{1'b0}};
        w_sel_data = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sel_reg  = w_sel_reg
                       | ({REG_ADDR_WIDTH{w_grant[i]}}
                          & wb_reg[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]);
            w_sel_data = w_sel_data
                       | ({DATA_WIDTH{w_grant[i]}}
                          & wb_data[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    assign w_sel_is_r0 = (w_sel_reg == {REG_ADDR_WIDTH{1'b0}});

    // Write stage: load the winner one cycle after the grant. A write to
    // r0 still loads index and data, but its enable stays low. Idle cycles
    // drop the enable and keep index and data.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_write_en   <= 1'b0;
            r_write_reg  <= {REG_ADDR_WIDTH{1'b0}};
            r_write_data <= {DATA_WIDTH{1'b0}};
        end else if (w_grant_valid) begin
            r_write_en   <= !w_sel_is_r0;
            r_write_reg  <= w_sel_reg;
            r_write_data <= w_sel_data;
        end else begin
            r_write_en   <= 1'b0;
            r_write_reg  <= r_write_reg;
            r_write_data <= r_write_data;
        end
    end

    assign ctrl_writeEnable = r_write_en;
    assign ctrl_writeReg    = r_write_reg;
    assign data_writeReg    = r_write_data;

    // ------------------------------------------------------------------
    // Pending-write scoreboard
    // ------------------------------------------------------------------

    // Next busy state. The clear is applied first and the set second, so a
    // fresh allocation of the register being committed keeps it busy: the
    // new producer supersedes the write that is retiring. Bit 0 is forced
    // low last.
    always_comb begin
        w_busy_next = r_busy;
        if (r_write_en) begin
            w_busy_next[r_write_reg] = 1'b0;
        end else begin
            w_busy_next = w_busy_next;
        end
        if (alloc_valid && (alloc_reg != {REG_ADDR_WIDTH{1'b0}})) begin
            w_busy_next[alloc_reg] = 1'b1;
        end else begin
            w_busy_next = w_busy_next;
        end
        w_busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_busy <= {NUM_REGS{1'b0}};
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // Operand lookups read the registered state. There is no bypass, so a
    // register committing this cycle still reads busy until the edge.
    assign busyA       = r_busy[query_regA];
    assign busyB       = r_busy[query_regB];
    assign busy_vector = r_busy;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between NUM_REQ writeback sources (ALU, multdiv, load unit).
- Round-robin grant, with one registered write stage that drives the regfile write port.
- Keeps a 32-entry pending-write (busy) scoreboard so issue logic can stall on operands that are not yet written back.
- Sits between the execution units and the regfile; the regfile's write-port inputs connect directly to this block's outputs.

Parameters:
- NUM_REQ, 3, number of writeback requesters (index 0 = ALU, 1 = multdiv, 2 = load).
- DATA_WIDTH, 32, writeback data width.
- REG_ADDR_WIDTH, 5, register index width (32 registers).

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- ctrl_reset  input  1  asynchronous, active-high reset.
- wb_req  input  NUM_REQ  per-requester writeback request.
- wb_reg  input  NUM_REQ*REG_ADDR_WIDTH  destination register; requester i at [5i+4:5i].
- wb_data  input  NUM_REQ*DATA_WIDTH  writeback data; requester i at [32i+31:32i].
- wb_grant  output  NUM_REQ  one-hot accept, combinational from wb_req and the pointer.
- alloc_valid  input  1  issue stage allocates a destination register this cycle.
- alloc_reg  input  REG_ADDR_WIDTH  register being allocated.
- query_regA  input  REG_ADDR_WIDTH  operand A register to check.
- query_regB  input  REG_ADDR_WIDTH  operand B register to check.
- busyA  output  1  busy[query_regA].
- busyB  output  1  busy[query_regB].
- busy_vector  output  32  full scoreboard.
- ctrl_writeEnable  output  1  regfile write enable (registered).
- ctrl_writeReg  output  REG_ADDR_WIDTH  regfile write index (registered).
- data_writeReg  output  DATA_WIDTH  regfile write data (registered).

Behaviour:
- Reset:
  - Asynchronous: rr_ptr=0, busy=0, ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
  - wb_grant is forced to 0 while ctrl_reset is high.
- Handshake:
  - A requester holds wb_req, wb_reg and wb_data stable until it sees wb_grant[i]=1.
  - The transfer completes on the clock edge where grant is high.
  - At most one grant bit is set per cycle.
  - wb_grant[i] is never high unless wb_req[i] is high.
- Arbitration:
  - Search order is rr_ptr, rr_ptr+1, … modulo NUM_REQ; the first requester found is granted.
  - After a grant to i, rr_ptr <= (i+1) mod NUM_REQ.
  - With no requests, rr_ptr holds.
  - A lone requester is granted every cycle (full throughput).
- Write stage (latency 1): on the edge after a grant:
  - ctrl_writeReg <= wb_reg[i] and data_writeReg <= wb_data[i].
  - ctrl_writeEnable <= 1, except when wb_reg[i]==0: the write is dropped, ctrl_writeEnable <= 0, and the grant is still given.
  - In a cycle with no grant, ctrl_writeEnable <= 0; ctrl_writeReg and data_writeReg hold their values.
- Scoreboard:
  - Set: busy[alloc_reg] <= 1 on an edge with alloc_valid=1 and alloc_reg!=0.
  - Clear: busy[ctrl_writeReg] <= 0 on an edge where ctrl_writeEnable=1. This is the same edge on which the regfile commits the write.
  - Simultaneous set and clear of the same register: set wins, because the new allocation supersedes the old write.
  - busy[0] is always 0.
  - busyA and busyB are combinational lookups of the current busy state, with no bypass. A register being written this cycle still reads busy=1 until the edge.
- Reset mid-operation: an in-flight write-stage entry is discarded, with no regfile write. Requesters must re-request after reset deasserts.
- Granting does not check busy; clearing on a write to a non-busy register is harmless.

Test Plan:
- Reset: assert ctrl_reset asynchronously mid-cycle with req=3'b111 -> wb_grant=0, ctrl_writeEnable=0, busy_vector=0 immediately. The first grant after release goes to requester 0.
- Round-robin: hold req=3'b111 with wb_reg={r3,r2,r1} and data {0xC,0xB,0xA} for 4 cycles.
  - Grants must be 001, 010, 100, 001.
  - Starting one cycle later, ctrl_writeReg must be 1,2,3,1 with data_writeReg 0xA, 0xB, 0xC, 0xA and ctrl_writeEnable=1.
- Fairness/hold: req=3'b101 continuously -> grants alternate 001, 100; requester 1 gets no grant.
- r0 drop: requester 2 writes r0 with 0xDEAD -> wb_grant=100, and ctrl_writeEnable stays 0 the next cycle.
- Scoreboard:
  - alloc r5 -> busyA=1 for query_regA=5 from the next cycle.
  - Requester 0 writes r5 -> busy[5] clears on the edge where ctrl_writeEnable=1 with ctrl_writeReg=5.
  - Allocating r5 again on that same edge leaves busy[5]=1.
- alloc_reg=0 with alloc_valid=1 -> busy_vector remains 0.
